// File: rtl/uart_tx_fifo_if.sv
// Byte-write and UART transmitter handshake bundle for uart_tx_fifo.
// The master drives bytes in and models the transmitter; the slave is the FIFO.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;

  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, overflow, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, overflow, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// Define UART_TX_FIFO_OVERFLOW_EN to get a sticky flag for dropped writes.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t         r_state;
  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [AW:0]    r_count;
  logic           r_txStart;
  logic [7:0]     r_txData;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;

  // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.wr_en && !w_full;
  assign w_pop   = (r_state == IDLE) && !w_empty && !bus.tx_busy;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_txStart <= 1'b0;
      r_txData  <= 8'h00;
    end else begin
      r_txStart <= 1'b0;

      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr  <= r_rdPtr + 1'b1;
        r_txData <= r_mem[r_rdPtr];
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Busy must be seen high then low before the next byte can be popped.
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state   <= START;
            r_txStart <= 1'b1;
          end
        end
        START: begin
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = r_count;
  assign bus.tx_start = r_txStart;
  assign bus.tx_data  = r_txData;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard on tx_start plus a table for fill/overflow.
// Expected overflow follows UART_TX_FIFO_OVERFLOW_EN.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int NVEC  = DEPTH + 1;

`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        expAccept;
    logic [AW:0] expCount;
    logic        expFull;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic autoBusy;
  logic manualBusy;
  logic modelBusy;
  int   busyLeft;
  int   errors = 0;
  int   checks = 0;
  int   pulseCount = 0;
  logic [7:0] sbQueue [$];
  vec_t vecs [NVEC];

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.tx_busy = autoBusy ? modelBusy : manualBusy;

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] data);
    bus.wr_en   = we;
    bus.wr_data = data;
    @(posedge clk);
    #1;
  endtask

  // Waits until every queued byte has been sent and the transmitter model has gone quiet.
  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    bus.wr_en = 1'b0;
    while ((sbQueue.size() != 0 || bus.empty !== 1'b1 || busyLeft != 0 || bus.tx_busy !== 1'b0) && n < budget) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL %s_timeout: actual=%0d pending bytes required=0", name, sbQueue.size());
    end
    repeat (3) applyStimulus(1'b0, 8'h00);
  endtask

  // Transmitter model: busy high for 10 cycles starting one cycle after each tx_start.
  initial begin
    modelBusy = 1'b0;
    busyLeft  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (autoBusy) begin
        if (busyLeft > 0) begin
          modelBusy = 1'b1;
          busyLeft--;
        end else begin
          modelBusy = 1'b0;
        end
        if (bus.tx_start === 1'b1) begin
          busyLeft = 10;
        end
      end
    end
  end

  initial begin
    logic [7:0] expByte;
    forever begin
      @(posedge clk);
      #2;
      if (bus.tx_start === 1'b1) begin
        pulseCount++;
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_tx_start: actual tx_data=%0h required=no pulse", bus.tx_data);
        end else begin
          expByte = sbQueue.pop_front();
          checkOutput("tx_data_order", {24'h0, bus.tx_data}, {24'h0, expByte});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int pulsesBefore;
    logic [7:0] d;

    for (int i = 0; i < NVEC; i++) begin
      vecs[i].data      = 8'(8'h80 + i);
      vecs[i].expAccept = (i < DEPTH);
      vecs[i].expCount  = (AW+1)'((i < DEPTH) ? i + 1 : DEPTH);
      vecs[i].expFull   = (i >= DEPTH - 1);
    end

    reset_n     = 1'b0;
    autoBusy    = 1'b1;
    manualBusy  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("reset_empty",    bus.empty,    1);
    checkOutput("reset_full",     bus.full,     0);
    checkOutput("reset_count",    bus.count,    0);
    checkOutput("reset_tx_start", bus.tx_start, 0);
    checkOutput("reset_tx_data",  bus.tx_data,  0);
    checkOutput("reset_overflow", bus.overflow, 0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h00);

    $display("[TB] single byte latency");
    sbQueue.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5);
    checkOutput("single_count_n1",    bus.count,    1);
    checkOutput("single_tx_start_n1", bus.tx_start, 0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("single_tx_start_n2", bus.tx_start, 1);
    checkOutput("single_tx_data",     bus.tx_data,  8'hA5);
    checkOutput("single_count_n2",    bus.count,    0);
    waitDrain("single", 100);

    $display("[TB] ordering");
    pulsesBefore = pulseCount;
    for (int b = 1; b <= 4; b++) begin
      sbQueue.push_back(8'(b));
      applyStimulus(1'b1, 8'(b));
    end
    waitDrain("order", 300);
    checkOutput("order_pulses", pulseCount - pulsesBefore, 4);

    $display("[TB] fill and overflow");
    manualBusy = 1'b1;
    autoBusy   = 1'b0;
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].expAccept) sbQueue.push_back(vecs[i].data);
      applyStimulus(1'b1, vecs[i].data);
      checkOutput("fill_count", bus.count, vecs[i].expCount);
      checkOutput("fill_full",  bus.full,  vecs[i].expFull);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("ovf_flag",  bus.overflow, EXP_OVF);
    checkOutput("ovf_count", bus.count,    DEPTH);
    checkOutput("ovf_empty", bus.empty,    0);
    manualBusy = 1'b0;
    autoBusy   = 1'b1;
    waitDrain("ovf_drain", 600);
    checkOutput("ovf_sticky",      bus.overflow, EXP_OVF);
    checkOutput("ovf_drain_empty", bus.empty,    1);

    $display("[TB] simultaneous write and pop");
    manualBusy = 1'b1;
    autoBusy   = 1'b0;
    applyStimulus(1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      sbQueue.push_back(8'(8'hC0 + i));
      applyStimulus(1'b1, 8'(8'hC0 + i));
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("simul_pre_count", bus.count, 3);
    sbQueue.push_back(8'hC4);
    manualBusy = 1'b0;
    applyStimulus(1'b1, 8'hC4);
    checkOutput("simul_count",    bus.count,    3);
    checkOutput("simul_tx_start", bus.tx_start, 1);
    applyStimulus(1'b0, 8'h00);
    manualBusy = 1'b1;
    applyStimulus(1'b0, 8'h00);
    autoBusy = 1'b1;
    waitDrain("simul_drain", 300);

    $display("[TB] wrap with interleaved drains");
    pulsesBefore = pulseCount;
    for (int i = 0; i < 40; i++) begin
      d = 8'(8'h40 + i);
      sbQueue.push_back(d);
      applyStimulus(1'b1, d);
      repeat ((i % 4 == 3) ? 40 : 2) applyStimulus(1'b0, 8'h00);
    end
    waitDrain("wrap", 800);
    checkOutput("wrap_pulses", pulseCount - pulsesBefore, 40);

    $display("[TB] reset mid-transfer");
    autoBusy   = 1'b0;
    manualBusy = 1'b0;
    pulsesBefore = pulseCount;
    sbQueue.push_back(8'hE0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'hE0 + i));
    end
    manualBusy = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("midrst_pre_count", bus.count, 5);
    reset_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    reset_n = 1'b1;
    checkOutput("midrst_empty",    bus.empty,    1);
    checkOutput("midrst_count",    bus.count,    0);
    checkOutput("midrst_tx_start", bus.tx_start, 0);
    checkOutput("midrst_overflow", bus.overflow, 0);
    repeat (3) applyStimulus(1'b0, 8'h00);
    manualBusy = 1'b0;
    repeat (30) applyStimulus(1'b0, 8'h00);
    checkOutput("midrst_pulses", pulseCount - pulsesBefore, 1);
    checkOutput("midrst_final_empty", bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; legal values are powers of two from 4 to 256.
REQ-002 The block SHALL have derived localparam AW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset_n, input, width 1: synchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, width 1: write request for wr_data.
REQ-006 The block SHALL have port wr_data, input, width 8: byte to enqueue.
REQ-007 The block SHALL have port full, output, width 1: high when count == DEPTH.
REQ-008 The block SHALL have port empty, output, width 1: high when count == 0.
REQ-009 The block SHALL have port count, output, width AW+1: number of bytes stored.
REQ-010 The block SHALL have port overflow, output, width 1: sticky flag for a dropped write.
REQ-011 The block SHALL have port tx_start, output, width 1: one-cycle start pulse to the UART transmitter.
REQ-012 The block SHALL have port tx_data, output, width 8: byte for the transmitter.
REQ-013 The block SHALL have port tx_busy, input, width 1: transmitter busy, asserted one or more cycles after tx_start.

Function
REQ-014 Storage SHALL be a circular buffer with AW-bit wr_ptr/rd_ptr that wrap from DEPTH-1 to 0; the count register, not pointer comparison, SHALL define full and empty.
REQ-015 A write with wr_en=1 and full=0 SHALL store wr_data at wr_ptr, advance wr_ptr and increment count; the result is visible on count the next cycle.
REQ-016 A write with wr_en=1 and full=1 SHALL be dropped even if a pop occurs in the same cycle; pointers and count SHALL be unchanged.
REQ-017 A simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-018 The FSM SHALL have states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-019 IDLE -> START SHALL occur when count != 0 and tx_busy == 0: tx_data <= mem[rd_ptr], rd_ptr advances, count decrements (the pop).
REQ-020 In START, tx_start SHALL be 1 for exactly that cycle, then the FSM goes to WAIT_BUSY.
REQ-021 WAIT_BUSY -> WAIT_DONE SHALL occur when tx_busy == 1; otherwise the FSM stays.
REQ-022 WAIT_DONE -> IDLE SHALL occur when tx_busy == 0; otherwise the FSM stays.
REQ-023 tx_data SHALL hold stable from the pop until the next pop.
REQ-024 tx_start SHALL be a registered output; it SHALL be asserted only in START, and never twice without an intervening tx_busy high-to-low transition.
REQ-025 Latency: a write to an empty FIFO in IDLE with tx_busy=0 at cycle N SHALL produce tx_start=1 at cycle N+2 with tx_data equal to the written byte.
REQ-026 Back-to-back bytes SHALL issue with the minimum spacing of one IDLE cycle after tx_busy falls.

Reset
REQ-027 While reset_n=0 at a clock edge, the block SHALL set: state=IDLE, wr_ptr=rd_ptr=0, count=0, full=0, empty=1, tx_start=0, tx_data=8'h00, overflow=0.
REQ-028 Reset mid-transfer SHALL discard all stored bytes.
REQ-029 After reset mid-transfer, the block SHALL ignore any residual tx_busy until it is low in IDLE.
REQ-030 Memory contents need not be reset.

Configuration
REQ-031 With macro UART_TX_FIFO_OVERFLOW_EN defined, overflow SHALL set on any dropped write (REQ-016) and stay 1 until reset.
REQ-032 Without UART_TX_FIFO_OVERFLOW_EN, overflow SHALL be tied to 0 and no flag register SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-033 Single byte: after reset, write 8'hA5 with tx_busy=0 -> tx_start pulses 2 cycles later, tx_data=8'hA5, count returns to 0.
REQ-034 Ordering: write 8'h01..8'h04 back-to-back; the transmitter model holds tx_busy high 10 cycles starting 1 cycle after each tx_start -> exactly 4 tx_start pulses with tx_data 01,02,03,04 in order.
REQ-035 Full/overflow: hold tx_busy=1 and write 17 bytes with DEPTH=16 -> full=1, count=16, 17th byte dropped; overflow=1 with the macro, 0 without it.
REQ-036 Wrap: 40 writes and drains interleaved at DEPTH=16 -> all 40 bytes emerge in order.
REQ-037 Simultaneous: write at count=3 in the pop cycle -> count stays 3.
REQ-038 Reset mid-transfer: reset_n=0 for 1 cycle while in WAIT_DONE with 5 bytes queued -> empty=1, count=0, no further tx_start.
